// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the sequential divider.
// SEQ_DIVIDER_RADIX4_EN selects two restoring steps per cycle instead of one.
package seq_divider_pkg;

  localparam int DW = 16;

`ifdef SEQ_DIVIDER_RADIX4_EN
  localparam int STEPS_PER_CYCLE = 2;
`else
  localparam int STEPS_PER_CYCLE = 1;
`endif

  localparam int CALC_CYCLES = DW / STEPS_PER_CYCLE;
  localparam int CNT_W       = $clog2(CALC_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/seq_divider_32b_if.sv
// Operand/result handshake bundle between the divider and its producer/consumer.
interface seq_divider_32b_if #(
  parameter int W = seq_divider_pkg::DW
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_32b_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int W = DW
) (
  input  logic [W-1:0] r_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] r_o,
  output logic         q_bit_o
);
  logic [W:0] t;
  logic [W:0] diff;

  // The incoming remainder is always below the divisor, so its carry bit is
  // zero and only the low W bits are carried between steps.
  assign t       = {r_i, bit_i};
  assign diff    = t - {1'b0, divisor_i};
  assign q_bit_o = (t >= {1'b0, divisor_i});
  assign r_o     = q_bit_o ? diff[W-1:0] : t[W-1:0];
endmodule

// File: rtl/seq_divider_32b.sv
// Iterative 32/16 restoring divider with valid/ready handshakes on both sides.
// Defining SEQ_DIVIDER_RADIX4_EN chains two div_step stages per cycle.
module seq_divider_32b
  import seq_divider_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  seq_divider_32b_if.slave  dbus
);
  state_e             state_q;
  logic [DW-1:0]      r_q;
  logic [DW-1:0]      q_q;
  logic [DW-1:0]      divisor_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      quotient_q;
  logic [DW-1:0]      remainder_q;
  logic               dbz_q;
  logic               ovf_q;
  logic               out_valid_q;

  logic [STEPS_PER_CYCLE-1:0] qbit;
  logic [DW-1:0]              r_d;
  logic [DW-1:0]              q_d;

  // Stage gi consumes the dividend bit gi places below the current MSB.
  for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
    logic [DW-1:0] r_in;
    logic [DW-1:0] r_out;
    logic          qb;

    if (gi == 0) begin : g_first
      assign r_in = r_q;
    end else begin : g_next
      assign r_in = g_step[gi-1].r_out;
    end

    div_step #(.W(DW)) u_step (
      .r_i       (r_in),
      .bit_i     (q_q[DW-1-gi]),
      .divisor_i (divisor_q),
      .r_o       (r_out),
      .q_bit_o   (qb)
    );

    assign qbit[gi] = qb;
  end

  assign r_d = g_step[STEPS_PER_CYCLE-1].r_out;

  always_comb begin
    q_d = q_q << STEPS_PER_CYCLE;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      q_d[STEPS_PER_CYCLE-1-i] = qbit[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dbus.in_valid) begin
            if (dbus.divisor == '0 || dbus.dividend[2*DW-1:DW] >= dbus.divisor) begin
              dbz_q       <= (dbus.divisor == '0);
              ovf_q       <= (dbus.divisor != '0);
              quotient_q  <= '1;
              remainder_q <= '0;
              state_q     <= DONE;
            end else begin
              dbz_q     <= 1'b0;
              ovf_q     <= 1'b0;
              r_q       <= dbus.dividend[2*DW-1:DW];
              q_q       <= dbus.dividend[DW-1:0];
              divisor_q <= dbus.divisor;
              cnt_q     <= '0;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          // Last step publishes directly so out_valid rises on the same edge.
          if (cnt_q == CNT_W'(CALC_CYCLES - 1)) begin
            quotient_q  <= q_d;
            remainder_q <= r_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Exception results arrive here with out_valid still low; raise it one edge later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (dbus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbus.in_ready    = (state_q == IDLE);
  assign dbus.out_valid   = out_valid_q;
  assign dbus.quotient    = quotient_q;
  assign dbus.remainder   = remainder_q;
  assign dbus.div_by_zero = dbz_q;
  assign dbus.overflow    = ovf_q;
endmodule

// File: doc/seq_divider_32b.md
# seq_divider_32b

Sequential restoring divider: 32-bit dividend by 16-bit divisor, returning a 16-bit quotient and a 16-bit remainder. It is the inverse datapath of the 16×16 Dadda multiplier, so a product and one of its operands recover the other operand. It sits beside the multiplier in the arithmetic datapath and uses valid/ready handshakes on both sides. Computation is iterative, one quotient bit per cycle by default.

## Interface
- DW, 16, operand width; dividend is 2*DW, quotient, remainder and divisor are DW
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider idle, can accept operands
- dividend  input  2*DW  numerator
- divisor  input  DW  denominator
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  DW  result quotient
- remainder  output  DW  result remainder
- div_by_zero  output  1  divisor was 0 (qualified by out_valid)
- overflow  output  1  quotient does not fit in DW bits (qualified by out_valid)

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. When in_valid && in_ready at a clock edge, capture the operands. Operands are ignored after capture.
- Exception checks at capture:
  - divisor==0: div_by_zero=1.
  - Otherwise, if dividend[2DW-1:DW] >= divisor: overflow=1.
  - Either case: go directly to DONE with quotient=all-ones and remainder=0.
- Normal path: go to CALC.
  - Partial remainder R (DW+1 bits) is loaded with dividend[2DW-1:DW].
  - Shift register Q is loaded with dividend[DW-1:0].
  - Step counter is cleared.
- CALC step:
  - T = {R[DW-1:0], Q[DW-1]}.
  - If T >= divisor: R = T - divisor and the quotient bit is 1. Otherwise R = T and the quotient bit is 0.
  - Q = {Q[DW-2:0], quotient bit}.
  - After DW steps, go to DONE with quotient=Q and remainder=R[DW-1:0].
- DONE: out_valid=1. All outputs are held stable until out_valid && out_ready. On that edge go to IDLE, and out_valid drops next cycle.
- in_valid while not in IDLE is ignored. in_ready is 0 in CALC and DONE.
- Reset (any state, including mid-CALC): state=IDLE and the in-flight result is discarded.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.

## Timing
- Accept edge t0.
- Normal latency: out_valid is high from edge t0+DW (16 cycles). Radix-4 build: t0+DW/2 (8 cycles).
- Exception latency: out_valid is high from edge t0+1.
- Minimum issue interval: latency + 1 cycle.
  - The handshake-out edge returns the block to IDLE.
  - in_ready rises the following cycle.
  - No same-edge accept-and-complete.
- Backpressure: out_ready low holds DONE indefinitely. Outputs do not change.
- Outputs are registered; no combinational path from inputs to outputs except none (in_ready is derived from the state register).

## Configuration
- SEQ_DIVIDER_RADIX4_EN defined: two restoring steps are chained per cycle.
  - CALC lasts DW/2 cycles.
  - DW must be even.
  - Results are bit-identical to the radix-2 build.
- SEQ_DIVIDER_RADIX4_EN undefined: one step per cycle, CALC lasts DW cycles.
- Exception handling and handshakes are identical in both builds.

## Structure
- Package seq_divider_pkg contains:
  - the state enum (IDLE, CALC, DONE);
  - the DW default;
  - the STEPS_PER_CYCLE constant (1 or 2, selected by the macro);
  - CALC_CYCLES = DW/STEPS_PER_CYCLE;
  - the counter width, clog2(CALC_CYCLES+1).
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: R, next dividend bit, divisor.
  - Outputs: new R, quotient bit.
  - Instantiated once, or twice in series under SEQ_DIVIDER_RADIX4_EN.

## Test plan
- 0xFFFE0001 / 0xFFFF → quotient=0xFFFF, remainder=0x0000, flags 0; out_valid exactly 16 cycles after accept (8 in radix-4 build).
- 0x00000064 / 0x0007 → quotient=0x000E, remainder=0x0002; then 1000 random cases with dividend=a*b+r, b≠0, r<b → quotient=a, remainder=r, zero mismatches.
- 0x00000005 / 0x0000 → div_by_zero=1, overflow=0, quotient=0xFFFF, remainder=0; out_valid 1 cycle after accept.
- 0x00010000 / 0x0001 → overflow=1, div_by_zero=0, quotient=0xFFFF, remainder=0.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0; a second in_valid pulse during CALC/DONE is ignored (only one result produced).
- Assert rst at step 8 of CALC → next cycle in_ready=1, out_valid=0, all outputs 0; the next operation completes correctly.
